// File: rtl/rng_arb_pkg.sv
// Shared types and constants for the RNG round-robin arbiter.
// Holds the FSM state encoding and the counter-sizing helper.
package rng_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Cycles from the rng_gen strobe to the earliest rng_en response.
  localparam int RNG_LATENCY = 1;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last_grant+1,
// wrapping modulo NREQ.
module rr_arbiter
  import rng_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = cnt_width(NREQ - 1)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_valid
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_last_grant) + k) % NREQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one LFSR random source among NREQ requesters, redrawing values above
// each requester's inclusive limit and saturating once the retries run out.
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      data_out,
  output logic                  clipped,
  output logic                  err,
  output logic                  rng_gen,
  input  logic                  rng_en,
  input  logic [WIDTH-1:0]      rng_value,
  output logic                  busy
);

  localparam int IDW = cnt_width(NREQ - 1);
  localparam int RW  = cnt_width(MAX_RETRY);
  // A WAIT window shorter than the RNG latency could never see a response.
  localparam int WAIT_LIMIT = (TIMEOUT > RNG_LATENCY) ? TIMEOUT : RNG_LATENCY;
  localparam int TW  = cnt_width(WAIT_LIMIT);

  state_t          r_state;
  state_t          w_next_state;

  logic [NREQ-1:0] r_grant;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last_grant;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_result;
  logic [RW-1:0]   r_retry;
  logic [TW-1:0]   r_wait_cnt;
  logic            r_clip;
  logic            r_err;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_any_req;
  logic [WIDTH-1:0] w_sel_limit;
  logic            w_timeout;
  logic            w_in_range;
  logic            w_can_retry;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_grant_idx),
    .o_valid      (w_any_req)
  );

  always_comb begin
    w_sel_limit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_limit = limit[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_timeout   = (r_wait_cnt == TW'(WAIT_LIMIT));
  assign w_in_range  = (r_value <= r_limit);
  assign w_can_retry = (r_retry < RW'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state = ST_GEN;
        end
      end
      ST_GEN: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (rng_en) begin
          w_next_state = ST_CHECK;
        end else if (w_timeout) begin
          w_next_state = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (w_in_range || !w_can_retry) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_GEN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Requester 0 must win first after reset, so last_grant starts at NREQ-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_id         <= '0;
      r_last_grant <= IDW'(NREQ - 1);
      r_limit      <= '0;
      r_value      <= '0;
      r_result     <= '0;
      r_retry      <= '0;
      r_wait_cnt   <= '0;
      r_clip       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_grant;
            r_id     <= w_grant_idx;
            r_limit  <= w_sel_limit;
            r_retry  <= '0;
            r_result <= '0;
            r_clip   <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        ST_GEN: begin
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (rng_en) begin
            r_value <= rng_value;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_in_range) begin
            r_result <= r_value;
          end else if (w_can_retry) begin
            r_retry <= r_retry + 1'b1;
          end else begin
            r_result <= r_limit;
            r_clip   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_id;
        end
        default: begin
          r_retry <= '0;
        end
      endcase
    end
  end

  assign ack      = (r_state == ST_DONE) ? r_grant : '0;
  assign data_out = (r_state == ST_DONE) ? r_result : '0;
  assign clipped  = (r_state == ST_DONE) && r_clip;
  assign err      = (r_state == ST_DONE) && r_err;
  assign rng_gen  = (r_state == ST_GEN);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus randomized
// transactions against a cycle-count/result model of the draw-and-reject rules.
module tb_rng_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] limit;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      data_out;
  logic                  clipped;
  logic                  err;
  logic                  rng_gen;
  logic                  rng_en;
  logic [WIDTH-1:0]      rng_value;
  logic                  busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int draws[$];
  bit resp_on = 1'b1;
  bit stray_on = 1'b0;
  int resp_delay = 0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  int gen_count = 0;
  logic prev_gen = 1'b0;
  int model_last = NREQ - 1;

  rng_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .limit(limit), .ack(ack),
    .data_out(data_out), .clipped(clipped), .err(err), .rng_gen(rng_gen),
    .rng_en(rng_en), .rng_value(rng_value), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // RNG model: answers each rng_gen after resp_delay extra cycles, optional stray strobes.
  always @(negedge clk) begin
    if (busy !== 1'b1) pend = 1'b0;
    rng_en = 1'b0;
    if (stray_on) begin
      rng_en    = 1'($urandom_range(0, 1));
      rng_value = 4'($urandom_range(0, 15));
    end
    if (pend) begin
      if (!resp_on) begin
        rng_en = 1'b0;
      end else if (pend_cnt == 0) begin
        rng_en = 1'b1;
        if (draws.size() > 0) rng_value = 4'(draws.pop_front());
        else rng_value = 4'($urandom_range(0, 15));
        pend = 1'b0;
      end else begin
        rng_en = 1'b0;
        pend_cnt--;
      end
    end
    if (rng_gen === 1'b1) begin
      gen_count++;
      checks++;
      if (prev_gen === 1'b1) begin
        failures++;
        $display("[TB] FAIL gen_consecutive rng_gen high in two consecutive cycles at cycle %0d", cyc);
      end
      pend = 1'b1;
      pend_cnt = resp_delay;
    end
    prev_gen = rng_gen;
  end

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_limit(input int idx, input int v);
    limit[idx*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  // Starts at an IDLE negedge, runs one transaction, returns at the following IDLE negedge.
  task automatic drive_txn(input logic [NREQ-1:0] reqv, input bit drop, input bit wiggle,
                           output logic [NREQ-1:0] a, output logic [WIDTH-1:0] d,
                           output logic c, output logic e, output int lat, output int gens);
    int t0;
    bit got;
    req = reqv;
    t0 = cyc;
    gen_count = 0;
    got = 1'b0;
    a = '0; d = '0; c = 1'b0; e = 1'b0; lat = -1; gens = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (wiggle) limit = 16'($urandom);
      if (ack !== '0) begin
        got = 1'b1;
        a = ack; d = data_out; c = clipped; e = err;
        lat = cyc - t0;
        gens = gen_count;
      end
    end
    if (drop) req = got ? (req & ~a) : '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack got=%b want=0000", ack); end
    checks++; if (data_out !== 4'd0) begin failures++; $display("[TB] FAIL reset_data got=%0d want=0", data_out); end
    checks++; if (clipped !== 1'b0) begin failures++; $display("[TB] FAIL reset_clipped got=%b want=0", clipped); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err); end
    checks++; if (rng_gen !== 1'b0) begin failures++; $display("[TB] FAIL reset_rng_gen got=%b want=0", rng_gen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    model_last = NREQ - 1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete(); draws.push_back(9);
    set_limit(0, 15);
    drive_txn(4'b0001, 1'b1, 1'b0, a, d, c, e, lat, gens);
    checks++; if (a !== 4'b0001) begin failures++; $display("[TB] FAIL single_ack got=%b want=0001", a); end
    checks++; if (d !== 4'd9) begin failures++; $display("[TB] FAIL single_data got=%0d want=9", d); end
    checks++; if (c !== 1'b0 || e !== 1'b0) begin failures++; $display("[TB] FAIL single_flags got clip=%b err=%b want 0/0", c, e); end
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL single_latency got=%0d want=4", lat); end
    checks++; if (gens != 1) begin failures++; $display("[TB] FAIL single_gens got=%0d want=1", gens); end
    model_last = 0;
  endtask

  task automatic test_rejection();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete(); draws.push_back(12); draws.push_back(3);
    set_limit(1, 5);
    drive_txn(4'b0010, 1'b1, 1'b0, a, d, c, e, lat, gens);
    checks++; if (a !== 4'b0010) begin failures++; $display("[TB] FAIL reject_ack got=%b want=0010", a); end
    checks++; if (d !== 4'd3) begin failures++; $display("[TB] FAIL reject_data got=%0d want=3", d); end
    checks++; if (c !== 1'b0 || e !== 1'b0) begin failures++; $display("[TB] FAIL reject_flags got clip=%b err=%b want 0/0", c, e); end
    checks++; if (lat != 7) begin failures++; $display("[TB] FAIL reject_latency got=%0d want=7", lat); end
    checks++; if (gens != 2) begin failures++; $display("[TB] FAIL reject_gens got=%0d want=2", gens); end
    model_last = 1;
  endtask

  task automatic test_saturation();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete();
    repeat (MAX_RETRY + 1) draws.push_back(14);
    set_limit(2, 2);
    drive_txn(4'b0100, 1'b1, 1'b0, a, d, c, e, lat, gens);
    checks++; if (a !== 4'b0100) begin failures++; $display("[TB] FAIL sat_ack got=%b want=0100", a); end
    checks++; if (d !== 4'd2) begin failures++; $display("[TB] FAIL sat_data got=%0d want=2", d); end
    checks++; if (c !== 1'b1) begin failures++; $display("[TB] FAIL sat_clipped got=%b want=1", c); end
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL sat_err got=%b want=0", e); end
    checks++; if (lat != 4 + 3 * MAX_RETRY) begin failures++; $display("[TB] FAIL sat_latency got=%0d want=%0d", lat, 4 + 3 * MAX_RETRY); end
    checks++; if (gens != MAX_RETRY + 1) begin failures++; $display("[TB] FAIL sat_gens got=%0d want=%0d", gens, MAX_RETRY + 1); end
    model_last = 2;
  endtask

  task automatic test_limit_max();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete(); draws.push_back(15);
    set_limit(3, 15);
    drive_txn(4'b1000, 1'b1, 1'b0, a, d, c, e, lat, gens);
    checks++; if (a !== 4'b1000) begin failures++; $display("[TB] FAIL lmax_ack got=%b want=1000", a); end
    checks++; if (d !== 4'd15 || c !== 1'b0) begin failures++; $display("[TB] FAIL lmax_data got=%0d clip=%b want=15 clip=0", d, c); end
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL lmax_latency got=%0d want=4", lat); end
    model_last = 3;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete();
    resp_on = 1'b0;
    set_limit(0, 9);
    drive_txn(4'b0001, 1'b1, 1'b0, a, d, c, e, lat, gens);
    resp_on = 1'b1;
    checks++; if (a !== 4'b0001) begin failures++; $display("[TB] FAIL tmo_ack got=%b want=0001", a); end
    checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err got=%b want=1", e); end
    checks++; if (d !== 4'd0 || c !== 1'b0) begin failures++; $display("[TB] FAIL tmo_data got=%0d clip=%b want=0 clip=0", d, c); end
    checks++; if (lat != 2 + TIMEOUT + 1) begin failures++; $display("[TB] FAIL tmo_latency got=%0d want=%0d", lat, 2 + TIMEOUT + 1); end
    checks++; if (gens != 1) begin failures++; $display("[TB] FAIL tmo_gens got=%0d want=1", gens); end
    model_last = 0;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    int vals[5];
    int want[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
    draws.delete();
    for (int i = 0; i < NREQ; i++) set_limit(i, 15);
    for (int i = 0; i < 5; i++) begin
      vals[i] = $urandom_range(0, 15);
      draws.push_back(vals[i]);
    end
    for (int i = 0; i < 5; i++) begin
      drive_txn(4'b1111, 1'b0, 1'b0, a, d, c, e, lat, gens);
      checks++; if (a !== 4'(1 << want[i])) begin failures++; $display("[TB] FAIL fair_grant%0d got=%b want=%b", i, a, 4'(1 << want[i])); end
      checks++; if (d !== 4'(vals[i])) begin failures++; $display("[TB] FAIL fair_data%0d got=%0d want=%0d", i, d, vals[i]); end
    end
    req = '0;
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    draws.delete();
    resp_on = 1'b0;
    set_limit(2, 10);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_ack got=%b want=0000", ack); end
    checks++; if (busy !== 1'b0 || rng_gen !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle got busy=%b gen=%b want 0/0", busy, rng_gen); end
    rst = 1'b0;
    resp_on = 1'b1;
    draws.push_back(7);
    set_limit(0, 15);
    drive_txn(4'b0101, 1'b1, 1'b0, a, d, c, e, lat, gens);
    req = '0;
    checks++; if (a !== 4'b0001) begin failures++; $display("[TB] FAIL rstmid_first_grant got=%b want=0001", a); end
    checks++; if (d !== 4'd7 || lat != 4) begin failures++; $display("[TB] FAIL rstmid_result got data=%0d lat=%0d want 7/4", d, lat); end
    model_last = 0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] a; logic [WIDTH-1:0] d; logic c, e; int lat, gens;
    logic [NREQ-1:0] reqv;
    int dv[MAX_RETRY+1];
    int exp_id, exp_lim, exp_res, exp_n, dly;
    bit exp_clip;
    for (int it = 0; it < 12; it++) begin
      reqv = 4'($urandom_range(1, 15));
      limit = 16'($urandom);
      stray_on = 1'($urandom_range(0, 1));
      dly = stray_on ? 0 : $urandom_range(0, 2);
      resp_delay = dly;
      exp_id = rr_pick(model_last, reqv);
      exp_lim = int'(limit[exp_id*WIDTH +: WIDTH]);
      draws.delete();
      for (int i = 0; i <= MAX_RETRY; i++) begin
        dv[i] = $urandom_range(0, 15);
        draws.push_back(dv[i]);
      end
      exp_res = exp_lim; exp_clip = 1'b1; exp_n = MAX_RETRY + 1;
      for (int i = MAX_RETRY; i >= 0; i--) begin
        if (dv[i] <= exp_lim) begin exp_res = dv[i]; exp_clip = 1'b0; exp_n = i + 1; end
      end
      drive_txn(reqv, 1'b1, 1'b1, a, d, c, e, lat, gens);
      req = 4'($urandom_range(0, 15)) & req;
      checks++; if (a !== 4'(1 << exp_id)) begin failures++; $display("[TB] FAIL rand%0d_ack got=%b want=%b", it, a, 4'(1 << exp_id)); end
      checks++; if (d !== 4'(exp_res) || c !== exp_clip || e !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_result got d=%0d clip=%b err=%b want d=%0d clip=%b err=0", it, d, c, e, exp_res, exp_clip); end
      checks++; if (lat != 1 + exp_n * (3 + dly) || gens != exp_n) begin failures++; $display("[TB] FAIL rand%0d_timing got lat=%0d gens=%0d want lat=%0d gens=%0d", it, lat, gens, 1 + exp_n * (3 + dly), exp_n); end
      model_last = exp_id;
      req = '0;
    end
    stray_on = 1'b0;
    resp_delay = 0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    limit = '0;
    rng_en = 1'b0;
    rng_value = '0;
    test_reset();
    test_single();
    test_rejection();
    test_saturation();
    test_limit_max();
    test_timeout();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
